// File: rtl/fuzzy_pkg.sv
// Shared widths, captured-degree payload and FSM state type for the defuzzifier.
package fuzzy_pkg;

   localparam int unsigned DEG_W     = 8;
   localparam int unsigned NUM_W     = 18;
   localparam int unsigned DEN_W     = 10;
   localparam int unsigned PROD_W    = 2 * DEG_W;
   localparam int unsigned TERM_W    = 2;
   localparam int unsigned CNT_W     = 5;
   localparam int unsigned DIV_STEPS = NUM_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_DIV,
      ST_DONE
   } state_t;

   // Degrees frozen at start so later input changes cannot leak into the result
   typedef struct packed {
      logic [DEG_W-1:0] mu0;
      logic [DEG_W-1:0] mu1;
      logic [DEG_W-1:0] mu2;
   } mu_vec_t;

endpackage

// File: rtl/defuzz_divisor.sv
// Serial restoring divider: one quotient bit per cycle, MSB first, pulses done when finished.
module defuzz_divisor
   import fuzzy_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [NUM_W-1:0] i_dividend,
   input  logic [DEN_W-1:0] i_divisor,
   output logic             o_done,
   output logic [NUM_W-1:0] o_quotient,
   output logic             o_zero
);

   logic [DEN_W-1:0] r_rem;
   logic [NUM_W-1:0] r_quo;
   logic [DEN_W-1:0] r_dvs;
   logic [CNT_W-1:0] r_cnt;
   logic             r_active;
   logic             r_done;
   logic             r_zero;

   logic [DEN_W:0]   w_shift;
   logic [DEN_W-1:0] w_diff;
   logic             w_ge;

   // Trial subtraction; remainder always fits DEN_W bits because it stays below the divisor
   always_comb begin
      w_shift = {r_rem, r_quo[NUM_W-1]};
      w_ge    = (w_shift >= {1'b0, r_dvs});
      w_diff  = DEN_W'(w_shift - {1'b0, r_dvs});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
         r_zero   <= 1'b0;
      end else if (i_load) begin
         r_rem    <= '0;
         r_quo    <= i_dividend;
         r_dvs    <= i_divisor;
         r_cnt    <= CNT_W'(DIV_STEPS);
         r_active <= 1'b1;
         r_done   <= 1'b0;
         r_zero   <= (i_divisor == '0);
      end else if (r_active) begin
         r_rem    <= w_ge ? w_diff : w_shift[DEN_W-1:0];
         r_quo    <= {r_quo[NUM_W-2:0], w_ge};
         r_cnt    <= r_cnt - CNT_W'(1);
         r_active <= (r_cnt != CNT_W'(1));
         r_done   <= (r_cnt == CNT_W'(1));
      end else begin
         r_done   <= 1'b0;
      end
   end

   assign o_done     = r_done;
   assign o_quotient = r_quo;
   assign o_zero     = r_zero;

endmodule

// File: rtl/defuzzificador.sv
// Weighted-average defuzzifier over three output terms: shared-multiplier accumulate, then serial divide.
module defuzzificador
   import fuzzy_pkg::*;
#(
   parameter logic [DEG_W-1:0] C0 = 8'd0,
   parameter logic [DEG_W-1:0] C1 = 8'd128,
   parameter logic [DEG_W-1:0] C2 = 8'd255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEG_W-1:0] mu_0,
   input  logic [DEG_W-1:0] mu_1,
   input  logic [DEG_W-1:0] mu_2,
   input  logic             start,
   output logic [DEG_W-1:0] crisp,
   output logic             valid,
   output logic             busy,
   output logic             div_zero
);

   state_t            r_state;
   state_t            w_state_nxt;
   mu_vec_t           r_mu;
   logic [TERM_W-1:0] r_term;
   logic [NUM_W-1:0]  r_num;
   logic [DEN_W-1:0]  r_den;
   logic [DEG_W-1:0]  r_crisp;
   logic              r_valid;
   logic              r_busy;
   logic              r_div_zero;

   logic              w_capture;
   logic              w_acc_en;
   logic              w_load;
   logic              w_finish;
   logic [DEG_W-1:0]  w_mu_sel;
   logic [DEG_W-1:0]  w_c_sel;
   logic [PROD_W-1:0] w_prod;
   logic [NUM_W-1:0]  w_num_nxt;
   logic [DEN_W-1:0]  w_den_nxt;
   logic              w_div_done;
   logic [NUM_W-1:0]  w_quo;
   logic              w_zero;
   logic [DEG_W-1:0]  w_crisp_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_acc_en    = 1'b0;
      w_load      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_ACC;
            end
         end
         ST_ACC: begin
            w_acc_en = 1'b1;
            if (r_term == TERM_W'(2)) begin
               w_load      = 1'b1;
               w_state_nxt = ST_DIV;
            end
         end
         ST_DIV: begin
            if (w_div_done) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // One term per cycle through a single 8x8 multiplier
   always_comb begin
      w_mu_sel = r_mu.mu2;
      w_c_sel  = C2;
      case (r_term)
         TERM_W'(0): begin w_mu_sel = r_mu.mu0; w_c_sel = C0; end
         TERM_W'(1): begin w_mu_sel = r_mu.mu1; w_c_sel = C1; end
         default:    begin w_mu_sel = r_mu.mu2; w_c_sel = C2; end
      endcase
      w_prod    = w_mu_sel * w_c_sel;
      w_num_nxt = r_num + NUM_W'(w_prod);
      w_den_nxt = r_den + DEN_W'(w_mu_sel);
   end

   // Divider loads the completed sums on the same edge that adds the last term
   defuzz_divisor u_div (
      .clk        (clk),
      .rst_n      (rst),
      .i_load     (w_load),
      .i_dividend (w_num_nxt),
      .i_divisor  (w_den_nxt),
      .o_done     (w_div_done),
      .o_quotient (w_quo),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_crisp_nxt = (|w_quo[NUM_W-1:DEG_W]) ? {DEG_W{1'b1}} : w_quo[DEG_W-1:0];
      if (w_zero) w_crisp_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mu       <= '0;
         r_term     <= '0;
         r_num      <= '0;
         r_den      <= '0;
         r_crisp    <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_valid <= w_finish;
         if (w_capture) begin
            r_mu   <= '{mu0: mu_0, mu1: mu_1, mu2: mu_2};
            r_term <= '0;
            r_num  <= '0;
            r_den  <= '0;
            r_busy <= 1'b1;
         end
         if (w_acc_en) begin
            r_num  <= w_num_nxt;
            r_den  <= w_den_nxt;
            r_term <= r_term + TERM_W'(1);
         end
         if (w_finish) begin
            r_crisp    <= w_crisp_nxt;
            r_div_zero <= w_zero;
            r_busy     <= 1'b0;
         end
      end
   end

   assign crisp    = r_crisp;
   assign valid    = r_valid;
   assign busy     = r_busy;
   assign div_zero = r_div_zero;

endmodule

// File: tb/tb_defuzzificador.sv
// Randomized and directed checks of the defuzzifier against an arithmetic weighted-average model.
module tb_defuzzificador;

   localparam int CEN0 = 0;
   localparam int CEN1 = 128;
   localparam int CEN2 = 255;
   localparam int LATENCY = 22;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] mu_0, mu_1, mu_2;
   logic [7:0] crisp;
   logic       valid, busy, div_zero;

   int n_checks;
   int n_errors;

   defuzzificador #(.C0(8'd0), .C1(8'd128), .C2(8'd255)) dut (
      .clk      (clk),
      .rst      (rst),
      .mu_0     (mu_0),
      .mu_1     (mu_1),
      .mu_2     (mu_2),
      .start    (start),
      .crisp    (crisp),
      .valid    (valid),
      .busy     (busy),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_crisp(input int m0, input int m1, input int m2);
      int num, den, q;
      num = m0 * CEN0 + m1 * CEN1 + m2 * CEN2;
      den = m0 + m1 + m2;
      if (den == 0) return 0;
      q = num / den;
      return (q > 255) ? 255 : q;
   endfunction

   // Launch one computation; optionally poke start while busy and in the result cycle.
   task automatic run_op(input int m0, input int m1, input int m2, input int exp_c,
                         input bit exp_dz, input bit pulses, input string tag);
      int lat;
      int nvalid;
      lat = 0;
      mu_0 = 8'(m0); mu_1 = 8'(m1); mu_2 = 8'(m2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mu_0 = 8'($urandom); mu_1 = 8'($urandom); mu_2 = 8'($urandom);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 1) check({tag, "_busy"}, busy, 1);
         if (valid) begin
            lat = k;
            break;
         end
         start = pulses && (k == 5);
      end
      check({tag, "_latency"}, lat, LATENCY);
      check({tag, "_crisp"}, crisp, exp_c);
      check({tag, "_divzero"}, div_zero, exp_dz);
      check({tag, "_busy_done"}, busy, 0);
      if (pulses) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_valid_width"}, valid, 0);
      if (pulses) begin
         nvalid = 0;
         repeat (30) begin
            @(posedge clk); #1;
            if (valid) nvalid++;
         end
         check({tag, "_extra_valid"}, nvalid, 0);
         check({tag, "_idle_busy"}, busy, 0);
         check({tag, "_hold"}, crisp, exp_c);
      end
   endtask

   initial begin
      int m0, m1, m2, nvalid;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      start = 1'b0;
      mu_0 = '0; mu_1 = '0; mu_2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_crisp", crisp, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_divzero", div_zero, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      run_op(0, 255, 0, 128, 1'b0, 1'b0, "mid");
      run_op(255, 0, 255, 127, 1'b0, 1'b0, "ends");
      run_op(100, 0, 50, 85, 1'b0, 1'b0, "mix");
      run_op(0, 0, 200, 255, 1'b0, 1'b0, "top");
      run_op(0, 0, 0, 0, 1'b1, 1'b0, "zero");
      run_op(50, 60, 70, ref_crisp(50, 60, 70), 1'b0, 1'b1, "pulses");

      // Abort mid-divide: start then assert reset during DIV
      mu_0 = 8'd0; mu_1 = 8'd255; mu_2 = 8'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_crisp", crisp, 0);
      check("abort_valid", valid, 0);
      check("abort_divzero", div_zero, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      nvalid = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (valid) nvalid++;
      end
      check("abort_no_valid", nvalid, 0);
      run_op(100, 0, 50, 85, 1'b0, 1'b0, "after_abort");

      for (int i = 0; i < 40; i++) begin
         m0 = int'($urandom_range(0, 255));
         m1 = int'($urandom_range(0, 255));
         m2 = int'($urandom_range(0, 255));
         case ($urandom_range(0, 7))
            0: begin m0 = 0; m1 = 0; m2 = 0; end
            1: m0 = 0;
            2: m2 = 0;
            default: ;
         endcase
         run_op(m0, m1, m2, ref_crisp(m0, m1, m2), (m0 + m1 + m2) == 0, 1'b0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
